// File: rtl/line_fill_memory.sv
// Read-only line-fill memory: accepts one line request, waits LATENCY edges, then streams LINE_WORDS beats.
// Define MEM_CRITICAL_WORD_FIRST_EN to start each burst at the requested word instead of offset 0.
module line_fill_memory #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int LATENCY    = 8,
  parameter     INIT_FILE  = ""
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          mem_req,
  input  logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic                          mem_ack,
  output logic                          mem_busy,
  output logic                          mem_data_valid,
  output logic [DATA_WIDTH-1:0]         mem_data,
  output logic [$clog2(LINE_WORDS)-1:0] mem_word_idx,
  output logic                          mem_last
);

  localparam int OW = $clog2(LINE_WORDS);
  localparam int TW = ADDR_WIDTH - OW;
  localparam int CW = $clog2(LATENCY + 1);

`ifdef MEM_CRITICAL_WORD_FIRST_EN
  localparam logic CWF = 1'b1;
`else
  localparam logic CWF = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         tag_q, tag_d;
  logic [OW-1:0]         off_q, off_d;
  logic [OW-1:0]         beat_q, beat_d;
  logic                  ack_q, ack_d;
  logic                  busy_q, busy_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [OW-1:0]         idx_q, idx_d;

  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_word;

  // Offset arithmetic is OW bits wide, so it wraps inside the line and never touches the tag.
  assign rd_addr = {tag_q, off_q};
  assign rd_word = DATA_WIDTH'(32'hA500_0000) | DATA_WIDTH'(rd_addr);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    off_d   = off_q;
    beat_d  = beat_q;
    ack_d   = 1'b0;
    busy_d  = busy_q;
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          ack_d   = 1'b1;
          busy_d  = 1'b1;
          tag_d   = mem_addr[ADDR_WIDTH-1:OW];
          off_d   = mem_addr[OW-1:0] & {OW{CWF}};
          beat_d  = '0;
          cnt_d   = CW'(LATENCY - 1);
          state_d = (LATENCY == 1) ? BURST : WAIT;
        end
      end
      // Leaving WAIT one edge early lets BURST emit the first beat exactly LATENCY edges after acceptance.
      WAIT: begin
        if (cnt_q == CW'(1)) state_d = BURST;
        else                 cnt_d   = cnt_q - CW'(1);
      end
      BURST: begin
        if (last_q) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          valid_d = 1'b1;
          data_d  = rd_word;
          idx_d   = off_q;
          last_d  = (beat_q == OW'(LINE_WORDS - 1));
          off_d   = off_q + OW'(1);
          beat_d  = beat_q + OW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tag_q   <= '0;
      off_q   <= '0;
      beat_q  <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      off_q   <= off_d;
      beat_q  <= beat_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
    end
  end

  assign mem_ack        = ack_q;
  assign mem_busy       = busy_q;
  assign mem_data_valid = valid_q;
  assign mem_data       = data_q;
  assign mem_word_idx   = idx_q;
  assign mem_last       = last_q;

endmodule

// File: tb/tb_line_fill_memory.sv
// Scoreboard bench for line_fill_memory: a LATENCY=8 instance (d0) and a LATENCY=1 instance (d1).
module tb_line_fill_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        req_w  [2];
  logic [12:0] addr_w [2];
  logic        ack_w  [2];
  logic        busy_w [2];
  logic        vld_w  [2];
  logic        last_w [2];
  logic [31:0] data_w [2];
  logic [1:0]  idx_w  [2];

  line_fill_memory u_lat8 (
    .clk(clk), .reset(reset), .mem_req(req_w[0]), .mem_addr(addr_w[0]),
    .mem_ack(ack_w[0]), .mem_busy(busy_w[0]), .mem_data_valid(vld_w[0]),
    .mem_data(data_w[0]), .mem_word_idx(idx_w[0]), .mem_last(last_w[0])
  );

  line_fill_memory #(.LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset), .mem_req(req_w[1]), .mem_addr(addr_w[1]),
    .mem_ack(ack_w[1]), .mem_busy(busy_w[1]), .mem_data_valid(vld_w[1]),
    .mem_data(data_w[1]), .mem_word_idx(idx_w[1]), .mem_last(last_w[1])
  );

  typedef struct {
    int          dut;
    int          cyc;
    logic [31:0] data;
    logic [1:0]  idx;
    logic        last;
  } beat_t;

  typedef struct {
    int dut;
    int t0;
    int t1;
  } win_t;

  beat_t bq [$];
  win_t  aq [$];
  win_t  wq [$];
  int    cyc   = 0;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    seen [2] = '{0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push_fill(input int d, input logic [12:0] a, input int t, input int lat);
    logic [12:0] base;
    logic [1:0]  st;
    logic [1:0]  off;
    base = a & 13'h1FFC;
`ifdef MEM_CRITICAL_WORD_FIRST_EN
    st = a[1:0];
`else
    st = 2'd0;
`endif
    aq.push_back('{d, t, t});
    wq.push_back('{d, t, t + lat + 3});
    for (int i = 0; i < 4; i++) begin
      off = st + 2'(i);
      bq.push_back('{d, t + lat + i, 32'hA500_0000 | {19'd0, base | {11'd0, off}}, off, (i == 3)});
    end
  endfunction

  task automatic mon(input int d);
    int   ia;
    int   ib;
    logic eb;
    ia = -1;
    ib = -1;
    foreach (aq[i]) if (ia < 0 && aq[i].dut == d) ia = i;
    foreach (bq[i]) if (ib < 0 && bq[i].dut == d) ib = i;
    if (ack_w[d]) begin
      n_cmp++;
      if (ia < 0 || aq[ia].t0 != cyc) begin
        n_bad++;
        $display("FAIL ack_d%0d: ack high at cycle %0d, required at cycle %0d", d, cyc, (ia < 0) ? -1 : aq[ia].t0);
      end
      if (ia >= 0) aq.delete(ia);
    end else if (ia >= 0 && aq[ia].t0 <= cyc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ack_d%0d: ack low at cycle %0d, required high at cycle %0d", d, cyc, aq[ia].t0);
      aq.delete(ia);
    end
    if (vld_w[d]) begin
      n_cmp++;
      seen[d]++;
      if (ib < 0) begin
        n_bad++;
        $display("FAIL beat_d%0d: unexpected beat at cycle %0d data %h idx %0d", d, cyc, data_w[d], idx_w[d]);
      end else begin
        if (bq[ib].cyc != cyc || data_w[d] !== bq[ib].data || idx_w[d] !== bq[ib].idx || last_w[d] !== bq[ib].last) begin
          n_bad++;
          $display("FAIL beat_d%0d: got cyc %0d data %h idx %0d last %0d, required cyc %0d data %h idx %0d last %0d",
                   d, cyc, data_w[d], idx_w[d], last_w[d], bq[ib].cyc, bq[ib].data, bq[ib].idx, bq[ib].last);
        end
        bq.delete(ib);
      end
    end else if (ib >= 0 && bq[ib].cyc <= cyc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL beat_d%0d: no beat at cycle %0d, required data %h", d, cyc, bq[ib].data);
      bq.delete(ib);
    end
    eb = 1'b0;
    foreach (wq[i]) if (wq[i].dut == d && wq[i].t0 <= cyc && cyc <= wq[i].t1) eb = 1'b1;
    n_cmp++;
    if (busy_w[d] !== eb) begin
      n_bad++;
      $display("FAIL busy_d%0d: got %b at cycle %0d, required %b", d, busy_w[d], cyc, eb);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      mon(0);
      mon(1);
    end
  end

  task automatic check_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if ({ack_w[d], busy_w[d], vld_w[d], last_w[d]} !== 4'b0 || data_w[d] !== 32'h0 || idx_w[d] !== 2'd0) begin
        n_bad++;
        $display("FAIL %s_d%0d: ack %b busy %b vld %b last %b data %h idx %0d, required all zero",
                 tag, d, ack_w[d], busy_w[d], vld_w[d], last_w[d], data_w[d], idx_w[d]);
      end
    end
  endtask

  // One request pulse; optional one-cycle stray request poke_at cycles after acceptance.
  task automatic fill(input int d, input logic [12:0] a, input int lat, input int poke_at);
    int t;
    @(negedge clk);
    req_w[d] = 1'b1;
    addr_w[d] = a;
    t = cyc + 1;
    push_fill(d, a, t, lat);
    @(negedge clk);
    req_w[d] = 1'b0;
    addr_w[d] = 13'h0AAA;
    if (poke_at > 0) begin
      repeat (poke_at) @(negedge clk);
      req_w[d] = 1'b1;
      addr_w[d] = 13'h0100;
      @(negedge clk);
      req_w[d] = 1'b0;
    end
    repeat (lat + 8) @(negedge clk);
  endtask

  // Request held across two complete fills; re-acceptance lands lat+5 edges after the first.
  task automatic held(input int d, input logic [12:0] a, input int lat);
    int t;
    @(negedge clk);
    req_w[d] = 1'b1;
    addr_w[d] = a;
    t = cyc + 1;
    push_fill(d, a, t, lat);
    push_fill(d, a, t + lat + 5, lat);
    repeat (lat + 6) @(negedge clk);
    req_w[d] = 1'b0;
    repeat (lat + 8) @(negedge clk);
  endtask

  task automatic reset_mid();
    int t;
    int base;
    @(negedge clk);
    req_w[0] = 1'b1;
    addr_w[0] = 13'h0040;
    t = cyc + 1;
    aq.push_back('{0, t, t});
    wq.push_back('{0, t, t + 3});
    @(negedge clk);
    req_w[0] = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check_zero("reset_mid");
    @(negedge clk);
    reset = 1'b0;
    base = seen[0];
    repeat (20) @(negedge clk);
    n_cmp++;
    if (seen[0] != base) begin
      n_bad++;
      $display("FAIL post_reset_quiet: got %0d beats after reset, required 0", seen[0] - base);
    end
  endtask

  initial begin
    req_w[0] = 1'b0;
    req_w[1] = 1'b0;
    addr_w[0] = 13'h0;
    addr_w[1] = 13'h0;
    #1 reset = 1'b1;
    #1 check_zero("reset_init");
    repeat (3) @(negedge clk);
    reset = 1'b0;

    fill(0, 13'h0005, 8, 3);
    fill(0, 13'h1FFF, 8, 0);
    fill(0, 13'h0006, 8, 0);
    fill(1, 13'h0006, 1, 4);
    fill(1, 13'h000B, 1, 0);
    held(0, 13'h0002, 8);
    held(1, 13'h1FF1, 1);
    reset_mid();
    fill(0, 13'h00F3, 8, 0);
    repeat (4) @(negedge clk);

    n_cmp++;
    if (bq.size() != 0) begin
      n_bad++;
      $display("FAIL beats_left: got %0d undelivered beats, required 0", bq.size());
    end
    n_cmp++;
    if (aq.size() != 0) begin
      n_bad++;
      $display("FAIL acks_left: got %0d missing acks, required 0", aq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
